// File: rtl/imem_stream_loader.sv
// Streams a header (start address, word count) plus payload into the core's debug
// instruction-memory port, holding the core in reset until the load completes cleanly.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module imem_stream_loader #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    input  logic [XLEN-1:0]  s_data_i,
    output logic             s_ready_o,
    input  logic             soft_clear_i,
    output logic             dbg_wr_en_o,
    output logic [XLEN-1:0]  dbg_addr_o,
    output logic [XLEN-1:0]  dbg_instr_o,
    output logic             core_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_loaded_o
);

    typedef enum logic [2:0] {
        StIdle,
        StHdrCnt,
        StData,
        StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCheck,
`endif
        StFinish,
        StRun,
        StError
    } state_e;

    state_e            state_q;
    logic              dbg_wr_en_q;
    logic [XLEN-1:0]   dbg_addr_q;
    logic [XLEN-1:0]   dbg_instr_q;
    logic              core_rst_q;
    logic              done_q;
    logic              error_q;
    logic [CNT_W-1:0]  words_loaded_q;
    logic [CNT_W-1:0]  count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [XLEN-1:0]   csum_q;
`endif

    logic ready_state;
    logic busy_state;
    logic accept;
    logic start_ok;
    logic last_word;

    always_comb begin
        ready_state = 1'b0;
        busy_state  = 1'b0;
        case (state_q)
            StIdle, StRun:    ready_state = 1'b1;
            StHdrCnt, StData: begin
                ready_state = 1'b1;
                busy_state  = 1'b1;
            end
            StWrite:          busy_state  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
                ready_state = 1'b1;
                busy_state  = 1'b1;
            end
`endif
            default: begin
                ready_state = 1'b0;
                busy_state  = 1'b0;
            end
        endcase
    end

    // Ready is gated by reset so no word can be taken while the loader is held.
    assign s_ready_o = rst_ni & ready_state;
    assign accept    = s_valid_i & s_ready_o;
    assign start_ok  = (s_data_i[1:0] == 2'b00);
    assign last_word = ((words_loaded_q + CNT_W'(1)) == count_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            dbg_wr_en_q    <= 1'b0;
            dbg_addr_q     <= '0;
            dbg_instr_q    <= '0;
            core_rst_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            count_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StRun: begin
                    if (accept) begin
                        core_rst_q <= 1'b1;
                        if (!start_ok) begin
                            error_q <= 1'b1;
                            state_q <= StError;
                        end else begin
                            dbg_addr_q     <= s_data_i;
                            words_loaded_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum_q         <= '0;
`endif
                            state_q        <= StHdrCnt;
                        end
                    end
                end
                StHdrCnt: begin
                    if (accept) begin
                        if (s_data_i == '0) begin
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                            state_q    <= StFinish;
                        end else if (s_data_i > XLEN'(MAX_WORDS)) begin
                            error_q <= 1'b1;
                            state_q <= StError;
                        end else begin
                            count_q <= s_data_i[CNT_W-1:0];
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        dbg_instr_q <= s_data_i;
                        dbg_wr_en_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q      <= csum_q ^ s_data_i;
`endif
                        state_q     <= StWrite;
                    end
                end
                StWrite: begin
                    dbg_wr_en_q    <= 1'b0;
                    dbg_addr_q     <= dbg_addr_q + XLEN'(ADDR_STEP);
                    words_loaded_q <= words_loaded_q + CNT_W'(1);
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q <= StCheck;
`else
                        done_q     <= 1'b1;
                        core_rst_q <= 1'b0;
                        state_q    <= StFinish;
`endif
                    end else begin
                        state_q <= StData;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (accept) begin
                        if (s_data_i == csum_q) begin
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                            state_q    <= StFinish;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= StError;
                        end
                    end
                end
`endif
                StFinish: state_q <= StRun;
                StError: begin
                    if (soft_clear_i) begin
                        error_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dbg_wr_en_o    = dbg_wr_en_q;
    assign dbg_addr_o     = dbg_addr_q;
    assign dbg_instr_o    = dbg_instr_q;
    assign core_rst_o     = core_rst_q;
    assign busy_o         = busy_state;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_loaded_q;

endmodule
